udma_filter_rx_arb: RTL

UDMA_FILTER_RX_ARB -- requirements
Module: udma_filter_rx_arb

---
 rtl/udma_filter_rx_arb_if.sv | 42 ++++
 rtl/udma_filter_rx_arb.sv | 96 +++++++++
 2 files changed

// File: rtl/udma_filter_rx_arb_if.sv
// Bundle of the per-requester beat inputs and the shared rx channel beat
// toward uDMA, as seen by the rx arbiter.
//
// Handshake rule for both sides: a beat moves on a rising clk_i edge exactly
// when its valid and its ready are both high in the cycle before that edge.
// The source holds every field of a beat stable while it is offered. Ready
// may depend combinationally on valid, but valid never waits for ready.
//
// modport master : the arbiter (accepts requester beats, drives the channel)
// modport slave  : the environment (requesters and the uDMA channel)
interface udma_filter_rx_arb_if #(
   parameter int NB_CH          = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int L2_AWIDTH_NOAL = 15
);
   localparam int SRC_W = $clog2(NB_CH);

   logic [NB_CH-1:0][L2_AWIDTH_NOAL-1:0] in_addr_i;
   logic [NB_CH-1:0][1:0]                in_datasize_i;
   logic [NB_CH-1:0][DATA_WIDTH-1:0]     in_data_i;
   logic [NB_CH-1:0]                     in_valid_i;
   logic [NB_CH-1:0]                     in_ready_o;

   logic [L2_AWIDTH_NOAL-1:0]            out_addr_o;
   logic [1:0]                           out_datasize_o;
   logic [DATA_WIDTH-1:0]                out_data_o;
   logic [SRC_W-1:0]                     out_src_o;
   logic                                 out_valid_o;
   logic                                 out_ready_i;

   modport master (
      input  in_addr_i, in_datasize_i, in_data_i, in_valid_i, out_ready_i,
      output in_ready_o, out_addr_o, out_datasize_o, out_data_o, out_src_o,
      output out_valid_o
   );

   modport slave (
      output in_addr_i, in_datasize_i, in_data_i, in_valid_i, out_ready_i,
      input  in_ready_o, out_addr_o, out_datasize_o, out_data_o, out_src_o,
      input  out_valid_o
   );
endinterface

// File: rtl/udma_filter_rx_arb.sv
// Rx arbiter: merges NB_CH requester beat streams onto one registered uDMA
// rx channel. Per-beat arbitration, round-robin or fixed (lowest index wins),
// selected live by cfg_prio_i. One-cycle latency, full throughput.
module udma_filter_rx_arb #(
   parameter int NB_CH          = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int L2_AWIDTH_NOAL = 15
) (
   input logic                  clk_i,
   input logic                  resetn_i,
   input logic                  cfg_prio_i,
   udma_filter_rx_arb_if.master bus
);
   localparam int SRC_W = $clog2(NB_CH);

   // Output register (the only state besides the round-robin pointer)
   logic                      r_valid;
   logic [L2_AWIDTH_NOAL-1:0] r_addr;
   logic [1:0]                r_size;
   logic [DATA_WIDTH-1:0]     r_data;
   logic [SRC_W-1:0]          r_src;
   logic [SRC_W-1:0]          r_last;

   logic                      load;
   logic                      pick_found;
   logic [SRC_W-1:0]          pick_idx;
   logic [NB_CH-1:0]          in_ready;

   // Scan candidates from the lowest-preference position to the highest so
   // the final hit is the winner. Round-robin starts just after last and
   // wraps; fixed priority simply prefers the lowest index.
   function automatic logic [SRC_W:0] arb_pick(
      input logic [NB_CH-1:0] req,
      input logic             prio,
      input logic [SRC_W-1:0] last
   );
      logic             found;
      logic [SRC_W-1:0] idx;
      int               j;
      found = 1'b0;
      idx   = '0;
      for (int k = NB_CH; k >= 1; k--) begin
         j = prio ? (k - 1) : ((int'(last) + k) % NB_CH);
         if (req[SRC_W'(j)]) begin
            found = 1'b1;
            idx   = SRC_W'(j);
         end
      end
      return {found, idx};
   endfunction

   assign {pick_found, pick_idx} = arb_pick(bus.in_valid_i, cfg_prio_i, r_last);

   // The output register can take a new beat when empty or being drained
   assign load = ~r_valid | bus.out_ready_i;

   // One-hot accept toward the winner; nothing is accepted while in reset
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NB_CH; i++) begin
         in_ready[i] = resetn_i & load & pick_found & (pick_idx == SRC_W'(i));
      end
   end

   assign bus.in_ready_o = in_ready;

   // Capture the winning beat; clear valid when drained with nothing new
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_size  <= '0;
         r_data  <= '0;
         r_src   <= '0;
         r_last  <= SRC_W'(NB_CH - 1);
      end else if (load) begin
         r_valid <= pick_found;
         if (pick_found) begin
            r_addr <= bus.in_addr_i[pick_idx];
            r_size <= bus.in_datasize_i[pick_idx];
            r_data <= bus.in_data_i[pick_idx];
            r_src  <= pick_idx;
            // Fixed-priority grants leave the rotation where it was
            if (!cfg_prio_i) begin
               r_last <= pick_idx;
            end
         end
      end
   end

   assign bus.out_valid_o    = r_valid;
   assign bus.out_addr_o     = r_addr;
   assign bus.out_datasize_o = r_size;
   assign bus.out_data_o     = r_data;
   assign bus.out_src_o      = r_src;
endmodule
